// File: rtl/router_port_receiver.sv
// Destination-side packet sink for one router output port.
// Pops one packet (header, len payload bytes, parity), streams every byte out,
// recomputes parity, checks the header address and aborts on a starved FIFO.
// Optional build macro ROUTER_RX_STATS_EN adds saturating pkt_count/err_count outputs.
module router_port_receiver #(
    parameter logic [1:0]  PORT_ID = 2'd0,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        rx_en,
    input  logic        vld_out,
    input  logic [7:0]  data_out,
    output logic        read_enb,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        byte_last,
    output logic        pkt_done,
    output logic [5:0]  pkt_len,
    output logic [1:0]  pkt_addr,
    output logic        parity_err,
    output logic        addr_err,
    output logic        trunc_err,
    output logic        rx_busy
`ifdef ROUTER_RX_STATS_EN
    ,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
`endif
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StHdrPop,
        StHdrCap,
        StBody,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  remaining_q, remaining_d;   // body pops still to issue (len+1 at start)
    logic [7:0]  starve_q, starve_d;
    logic [7:0]  acc_q, acc_d;               // running XOR of header and payload
    logic        pend_q, pend_d;             // a popped byte arrives on data_out this cycle
    logic        pend_last_q, pend_last_d;   // ... and it is the parity byte
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_valid_q, byte_valid_d;
    logic        byte_last_q, byte_last_d;
    logic [5:0]  pkt_len_q, pkt_len_d;
    logic [1:0]  pkt_addr_q, pkt_addr_d;
    logic        parity_err_q, parity_err_d;
    logic        addr_err_q, addr_err_d;
    logic        trunc_err_q, trunc_err_d;

    logic        pop;
    logic [7:0]  starve_inc;

    // Pop request: only ever raised while the port FIFO reports data.
    always_comb begin
        read_enb = 1'b0;
        unique case (state_q)
            StHdrPop: read_enb = vld_out;
            StBody:   read_enb = vld_out && (remaining_q != 7'd0);
            default:  read_enb = 1'b0;
        endcase
    end

    assign pop        = read_enb && vld_out;
    assign starve_inc = starve_q + 8'd1;

    // Next-state and datapath updates for the receive FSM.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        starve_d     = starve_q;
        acc_d        = acc_q;
        pend_d       = pend_q;
        pend_last_d  = pend_last_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        byte_last_d  = 1'b0;
        pkt_len_d    = pkt_len_q;
        pkt_addr_d   = pkt_addr_q;
        parity_err_d = parity_err_q;
        addr_err_d   = addr_err_q;
        trunc_err_d  = trunc_err_q;

        unique case (state_q)
            StIdle: begin
                pend_d      = 1'b0;
                pend_last_d = 1'b0;
                if (rx_en && vld_out) begin
                    state_d = StHdrPop;
                end
            end
            StHdrPop: begin
                if (pop) begin
                    state_d = StHdrCap;
                end
            end
            StHdrCap: begin
                pkt_len_d    = data_out[7:2];
                pkt_addr_d   = data_out[1:0];
                acc_d        = data_out;
                remaining_d  = {1'b0, data_out[7:2]} + 7'd1;
                starve_d     = '0;
                pend_d       = 1'b0;
                pend_last_d  = 1'b0;
                byte_data_d  = data_out;
                byte_valid_d = 1'b1;
                parity_err_d = 1'b0;
                addr_err_d   = 1'b0;
                trunc_err_d  = 1'b0;
                state_d      = StBody;
            end
            StBody: begin
                // Capture the byte popped on the previous edge.
                if (pend_q) begin
                    byte_data_d  = data_out;
                    byte_valid_d = 1'b1;
                    if (pend_last_q) begin
                        byte_last_d  = 1'b1;
                        parity_err_d = (data_out != acc_q);
                        addr_err_d   = (pkt_addr_q != PORT_ID);
                        state_d      = StDone;
                    end else begin
                        acc_d = acc_q ^ data_out;
                    end
                end
                pend_d      = pop;
                pend_last_d = pop && (remaining_q == 7'd1);
                if (pop) begin
                    remaining_d = remaining_q - 7'd1;
                    starve_d    = '0;
                end else if ((remaining_q != 7'd0) && !vld_out) begin
                    starve_d = starve_inc;
                    if (starve_inc == TIMEOUT_W) begin
                        trunc_err_d = 1'b1;
                        addr_err_d  = (pkt_addr_q != PORT_ID);
                        state_d     = StDone;
                    end
                end
            end
            StDone: begin
                pend_d      = 1'b0;
                pend_last_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            starve_q     <= '0;
            acc_q        <= '0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            pkt_len_q    <= '0;
            pkt_addr_q   <= '0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
            trunc_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            starve_q     <= starve_d;
            acc_q        <= acc_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            byte_last_q  <= byte_last_d;
            pkt_len_q    <= pkt_len_d;
            pkt_addr_q   <= pkt_addr_d;
            parity_err_q <= parity_err_d;
            addr_err_q   <= addr_err_d;
            trunc_err_q  <= trunc_err_d;
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign byte_last  = byte_last_q;
    assign pkt_done   = (state_q == StDone);
    assign pkt_len    = pkt_len_q;
    assign pkt_addr   = pkt_addr_q;
    assign parity_err = parity_err_q;
    assign addr_err   = addr_err_q;
    assign trunc_err  = trunc_err_q;
    assign rx_busy    = (state_q != StIdle);

`ifdef ROUTER_RX_STATS_EN
    logic [15:0] pkt_count_q, pkt_count_d;
    logic [15:0] err_count_q, err_count_d;

    // Saturating packet and error counters, stepped once per pkt_done.
    always_comb begin
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        if (state_q == StDone) begin
            if (pkt_count_q != 16'hFFFF) begin
                pkt_count_d = pkt_count_q + 16'd1;
            end
            if ((parity_err_q || addr_err_q || trunc_err_q) && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_router_port_receiver.sv
// Directed bench for router_port_receiver: a queue-based model of the router
// port FIFO feeds the DUT; table vectors plus hand-written corner sequences.
module tb_router_port_receiver;

    logic       clock = 1'b0;
    logic       resetn;
    logic       rx_en;
    logic       vld_out;
    logic [7:0] data_out;
    logic       read_enb;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       pkt_done;
    logic [5:0] pkt_len;
    logic [1:0] pkt_addr;
    logic       parity_err;
    logic       addr_err;
    logic       trunc_err;
    logic       rx_busy;
`ifdef ROUTER_RX_STATS_EN
    logic [15:0] pkt_count;
    logic [15:0] err_count;
`endif

    always #5 clock = ~clock;

    router_port_receiver #(
        .PORT_ID (2'd2),
        .TIMEOUT (32)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .rx_en      (rx_en),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .read_enb   (read_enb),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .pkt_addr   (pkt_addr),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .trunc_err  (trunc_err),
        .rx_busy    (rx_busy)
`ifdef ROUTER_RX_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .err_count  (err_count)
`endif
    );

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] seed;
        logic [7:0] step;
        bit         force_par;
        logic [7:0] par_val;
        int         exp_pops;
        int         exp_len;
        int         exp_addr;
        int         exp_perr;
        int         exp_aerr;
    } vec_t;

    vec_t       vt [6];
    logic [7:0] fifo[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] rx_bytes[$];
    int         pops = 0;
    int         cyc = 0;
    int         last_pop_cyc = 0;
    int         viol = 0;
    bit         pop_will = 1'b0;
    int         nvec = 0;
    int         nfail = 0;

    int done_seen, done_cyc, last_cnt, last_idx;
    int s_pops, s_len, s_addr, s_perr, s_aerr, s_terr, s_renb;
    int s_done_next, s_renb_next, s_busy_next;

    // Router port model: one-cycle read latency, data changes just after the pop edge.
    initial begin
        vld_out  = 1'b0;
        data_out = 8'h00;
        forever begin
            @(posedge clock);
            cyc++;
            if (pop_will && fifo.size() != 0) last_pop_cyc = cyc;
            #1;
            if (pop_will && fifo.size() != 0) begin
                data_out = fifo.pop_front();
                pops++;
            end
            vld_out = (fifo.size() != 0);
        end
    end

    // Pops are decided mid-cycle when read_enb and vld_out are stable.
    always @(negedge clock) begin
        pop_will = read_enb && vld_out;
        if (resetn && read_enb && !vld_out) viol++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, int'({read_enb, byte_data, byte_valid, byte_last, pkt_done, pkt_len, pkt_addr,
                      parity_err, addr_err, trunc_err, rx_busy}), 0);
    endtask

    task automatic load_pkt(input logic [7:0] hdr, input logic [7:0] seed,
                            input logic [7:0] step, input int npay_in, input bit with_par,
                            input bit force_par, input logic [7:0] par_val);
        logic [7:0] p;
        logic [7:0] b;
        int         np;
        np = (npay_in < 0) ? int'(hdr[7:2]) : npay_in;
        p  = hdr;
        b  = seed;
        fifo.push_back(hdr);
        exp_bytes.push_back(hdr);
        for (int i = 0; i < np; i++) begin
            fifo.push_back(b);
            exp_bytes.push_back(b);
            p = p ^ b;
            b = b + step;
        end
        if (with_par) begin
            fifo.push_back(force_par ? par_val : p);
            exp_bytes.push_back(force_par ? par_val : p);
        end
    endtask

    task automatic wait_done(input int budget);
        rx_bytes.delete();
        last_cnt  = 0;
        last_idx  = -1;
        done_seen = 0;
        for (int i = 0; i < budget && done_seen == 0; i++) begin
            @(negedge clock);
            if (byte_valid) begin
                rx_bytes.push_back(byte_data);
                if (byte_last) begin
                    last_cnt++;
                    last_idx = rx_bytes.size() - 1;
                end
            end
            if (pkt_done) begin
                done_seen = 1;
                done_cyc  = cyc;
                s_pops    = pops;
                s_len     = int'(pkt_len);
                s_addr    = int'(pkt_addr);
                s_perr    = int'(parity_err);
                s_aerr    = int'(addr_err);
                s_terr    = int'(trunc_err);
                s_renb    = int'(read_enb);
            end
        end
        @(negedge clock);
        s_done_next = int'(pkt_done);
        s_renb_next = int'(read_enb);
        s_busy_next = int'(rx_busy);
    endtask

    task automatic check_pkt(input string nm, input int e_pops, input int e_len,
                             input int e_addr, input int e_perr, input int e_aerr,
                             input int e_terr);
        chk({nm, "_done"}, done_seen, 1);
        chk({nm, "_pops"}, s_pops, e_pops);
        chk({nm, "_len"}, s_len, e_len);
        chk({nm, "_addr"}, s_addr, e_addr);
        chk({nm, "_parity_err"}, s_perr, e_perr);
        chk({nm, "_addr_err"}, s_aerr, e_aerr);
        chk({nm, "_trunc_err"}, s_terr, e_terr);
        chk({nm, "_done_pulse"}, s_done_next, 0);
        chk({nm, "_idle_after"}, s_busy_next, 0);
        if (e_terr != 0) begin
            chk({nm, "_last_cnt"}, last_cnt, 0);
        end else begin
            chk({nm, "_last_cnt"}, last_cnt, 1);
            chk({nm, "_last_pos"}, last_idx, e_pops - 1);
        end
        chk({nm, "_nbytes"}, rx_bytes.size(), e_pops);
        for (int k = 0; k < e_pops && k < rx_bytes.size() && k < exp_bytes.size(); k++) begin
            chk($sformatf("%s_byte%0d", nm, k), int'(rx_bytes[k]), int'(exp_bytes[k]));
        end
        for (int k = 0; k < e_pops && exp_bytes.size() != 0; k++) void'(exp_bytes.pop_front());
    endtask

    task automatic apply_vec(input int i, input string nm);
        exp_bytes.delete();
        pops = 0;
        load_pkt(vt[i].hdr, vt[i].seed, vt[i].step, -1, 1'b1, vt[i].force_par, vt[i].par_val);
        rx_en = 1'b1;
        wait_done(300);
        check_pkt(nm, vt[i].exp_pops, vt[i].exp_len, vt[i].exp_addr, vt[i].exp_perr,
                  vt[i].exp_aerr, 0);
    endtask

    initial begin
        int bad;
        int reached;

        //          hdr    seed   step   force  par    pops len addr perr aerr
        vt[0] = '{8'h22, 8'hA5, 8'h1F, 1'b0, 8'h00, 10,  8,  2,   0,   0};
        vt[1] = '{8'h41, 8'h3C, 8'h09, 1'b0, 8'h00, 18, 16,  1,   0,   1};
        vt[2] = '{8'h22, 8'h00, 8'h00, 1'b1, 8'h23, 10,  8,  2,   1,   0};
        vt[3] = '{8'h02, 8'h00, 8'h00, 1'b0, 8'h00,  2,  0,  2,   0,   0};
        vt[4] = '{8'hFE, 8'h01, 8'h01, 1'b0, 8'h00, 65, 63,  2,   0,   0};
        vt[5] = '{8'h0F, 8'h10, 8'h01, 1'b1, 8'h00,  5,  3,  3,   1,   1};

        resetn = 1'b0;
        rx_en  = 1'b0;
        repeat (3) @(negedge clock);
        chk_zero("reset_state");
        resetn = 1'b1;
        @(negedge clock);

        // rx_en low must hold the receiver in IDLE even with data waiting.
        exp_bytes.delete();
        pops = 0;
        load_pkt(8'h22, 8'hA5, 8'h1F, -1, 1'b1, 1'b0, 8'h00);
        bad = 0;
        repeat (6) begin
            @(negedge clock);
            if (read_enb || rx_busy) bad++;
        end
        chk("rx_en_gate", bad, 0);
        chk("rx_en_gate_pops", pops, 0);
        rx_en = 1'b1;
        wait_done(300);
        check_pkt("gate", 10, 8, 2, 0, 0, 0);

        for (int i = 0; i < 6; i++) apply_vec(i, $sformatf("v%0d", i));

        // Zero-length packet followed immediately by another packet in the FIFO.
        exp_bytes.delete();
        pops = 0;
        load_pkt(8'h02, 8'h00, 8'h00, -1, 1'b1, 1'b0, 8'h00);
        load_pkt(8'h22, 8'h5A, 8'h0D, -1, 1'b1, 1'b0, 8'h00);
        rx_en = 1'b1;
        wait_done(300);
        check_pkt("b2b_first", 2, 0, 2, 0, 0, 0);
        chk("b2b_renb_in_done", s_renb, 0);
        chk("b2b_renb_in_idle", s_renb_next, 0);
        pops = 0;
        @(negedge clock);
        chk("b2b_renb_hdrpop", int'(read_enb), 1);
        wait_done(300);
        check_pkt("b2b_second", 10, 8, 2, 0, 0, 0);

        // Starvation after three payload bytes; rx_en dropped mid-packet.
        exp_bytes.delete();
        pops = 0;
        load_pkt(8'h22, 8'h31, 8'h07, 3, 1'b0, 1'b0, 8'h00);
        rx_en   = 1'b1;
        reached = 0;
        for (int i = 0; i < 20 && reached == 0; i++) begin
            @(negedge clock);
            if (pops >= 1) reached = 1;
        end
        chk("starve_hdr_popped", reached, 1);
        rx_en = 1'b0;
        wait_done(300);
        check_pkt("starve", 4, 8, 2, 0, 0, 1);
        chk("starve_latency", done_cyc - last_pop_cyc, 32);

        // Reset after the fourth pop, then a fresh packet.
        exp_bytes.delete();
        pops    = 0;
        load_pkt(8'h22, 8'h77, 8'h03, -1, 1'b1, 1'b0, 8'h00);
        rx_en   = 1'b1;
        reached = 0;
        for (int i = 0; i < 30 && reached == 0; i++) begin
            @(negedge clock);
            if (pops >= 4) reached = 1;
        end
        chk("rst_mid_reached", reached, 1);
        chk("rst_mid_busy_before", int'(rx_busy), 1);
        #1;
        resetn = 1'b0;
        fifo.delete();
        #1;
        chk_zero("rst_mid_outputs");
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clock);
            if (pkt_done || rx_busy) bad++;
        end
        chk("rst_mid_no_done", bad, 0);
        apply_vec(0, "post_rst");

        chk("renb_without_vld", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
